// File: rtl/fp_op_arbiter.sv
// Round-robin arbiter sharing one floating-point ALU between two requesters:
// start/done handshake, 16/32-bit result selection and a watchdog on alu_done.
module fp_op_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_mode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req0_round,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_mode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    input  logic        req1_round,
    output logic        req1_ready,
    output logic        alu_start,
    output logic        alu_mode,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_round,
    input  logic        alu_done,
    input  logic [15:0] r16,
    input  logic [31:0] r32,
    input  logic [4:0]  f16,
    input  logic [4:0]  f32,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        rsp_timeout,
    output logic        busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;
    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        prio;
    logic        owner;
    logic [15:0] count;
    logic        sel_mode;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [1:0]  sel_op;
    logic        sel_round;

    // Ready is gated by reset so nothing looks accepted while reset is held.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && reset) begin
            req0_ready = req0_valid & (~req1_valid | ~prio);
            req1_ready = req1_valid & (~req0_valid | prio);
        end
    end

    always_comb begin
        sel_mode  = req1_ready ? req1_mode  : req0_mode;
        sel_a     = req1_ready ? req1_a     : req0_a;
        sel_b     = req1_ready ? req1_b     : req0_b;
        sel_op    = req1_ready ? req1_op    : req0_op;
        sel_round = req1_ready ? req1_round : req0_round;
    end

    assign alu_start = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            count       <= '0;
            alu_mode    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            alu_round   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner     <= req1_ready;
                        prio      <= ~req1_ready;
                        alu_mode  <= sel_mode;
                        alu_a     <= sel_mode ? sel_a : {16'h0000, sel_a[15:0]};
                        alu_b     <= sel_mode ? sel_b : {16'h0000, sel_b[15:0]};
                        alu_op    <= sel_op;
                        alu_round <= sel_round;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done arriving in the expiry cycle takes precedence.
                    if (alu_done) begin
                        rsp_result  <= alu_mode ? r32 : {16'h0000, r16};
                        rsp_flags   <= alu_mode ? f32 : f16;
                        rsp_timeout <= 1'b0;
                        rsp_id      <= owner;
                        state       <= RESP;
                    end else if (count == LAST) begin
                        rsp_result  <= '0;
                        rsp_flags   <= '0;
                        rsp_timeout <= 1'b1;
                        rsp_id      <= owner;
                        state       <= RESP;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_op_arbiter.sv
// Randomized scoreboard bench for fp_op_arbiter: a cycle-level model predicts
// grants and responses; a separate monitor checks every rsp_valid strobe.
module tb_fp_op_arbiter;
    localparam int unsigned TO   = 8;
    localparam int unsigned NOPS = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  p_valid, p_mode, p_round;
    logic [31:0] p_a [2];
    logic [31:0] p_b [2];
    logic [1:0]  p_op [2];
    logic        req0_ready, req1_ready, alu_start, alu_mode, alu_round, alu_done;
    logic        rsp_valid, rsp_id, rsp_timeout, busy;
    logic [31:0] alu_a, alu_b, r32, rsp_result;
    logic [1:0]  alu_op;
    logic [15:0] r16;
    logic [4:0]  f16, f32, rsp_flags;

    int unsigned cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [4:0]  flg;
        logic        tmo;
        int unsigned at;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t e;
    logic [38:0] last_rsp;

    fp_op_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(p_valid[0]), .req0_mode(p_mode[0]), .req0_a(p_a[0]), .req0_b(p_b[0]),
        .req0_op(p_op[0]), .req0_round(p_round[0]), .req0_ready(req0_ready),
        .req1_valid(p_valid[1]), .req1_mode(p_mode[1]), .req1_a(p_a[1]), .req1_b(p_b[1]),
        .req1_op(p_op[1]), .req1_round(p_round[1]), .req1_ready(req1_ready),
        .alu_start(alu_start), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_round(alu_round), .alu_done(alu_done),
        .r16(r16), .r32(r32), .f16(f16), .f32(f32),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic new_req(input int i);
        p_mode[i]  = 1'($urandom);
        p_a[i]     = $urandom;
        p_b[i]     = $urandom;
        p_op[i]    = 2'($urandom);
        p_round[i] = 1'($urandom);
    endtask

    // Response monitor: every strobe pops one prediction; fields must hold between strobes.
    always @(negedge clk) begin
        if (!reset) begin
            last_rsp = '0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected at cycle %0d: got rsp_valid=1 id=%0d, required no response", cyc, rsp_id);
            end else begin
                e = exp_q.pop_front();
                check("rsp_cycle", 96'(cyc), 96'(e.at));
                check("rsp_id", 96'(rsp_id), 96'(e.id));
                check("rsp_payload", {rsp_timeout, rsp_flags, rsp_result}, {e.tmo, e.flg, e.res});
            end
            last_rsp = {rsp_id, rsp_timeout, rsp_flags, rsp_result};
        end else begin
            check("rsp_hold", {rsp_id, rsp_timeout, rsp_flags, rsp_result}, last_rsp);
        end
    end

    initial begin
        logic [1:0]  exp_r, acc_mask;
        logic        w, have_op, done_en, mprio;
        int unsigned acc_c, rsp_c, done_c, d, nacc, guard;
        logic [67:0] exp_opnd;
        logic [15:0] pr16;
        logic [31:0] pr32;
        logic [4:0]  pf16, pf32;
        rsp_t        x;

        have_op = 0; done_en = 0; mprio = 0; acc_mask = '0; nacc = 0; guard = 0;
        acc_c = 0; rsp_c = 0; done_c = 0; exp_opnd = '0;
        pr16 = '0; pr32 = '0; pf16 = '0; pf32 = '0;
        reset = 1'b0; p_valid = '0; alu_done = 1'b0;
        r16 = '0; r32 = '0; f16 = '0; f32 = '0;
        new_req(0);
        new_req(1);
        repeat (3) @(negedge clk);
        check("reset_state", {req0_ready, req1_ready, alu_start, alu_mode, alu_a, alu_b, alu_op,
                              alu_round, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_timeout, busy}, '0);

        // Directed opening: both requesters contend; req0 16-bit first, then req1 32-bit.
        p_mode = 2'b10;
        p_a[0] = 32'h12343C00; p_b[0] = 32'h56784000; p_op[0] = 2'd0; p_round[0] = 1'b0;
        p_a[1] = 32'h3F800000; p_b[1] = 32'h40000000; p_op[1] = 2'd1; p_round[1] = 1'b1;
        p_valid = 2'b11;
        @(posedge clk);
        #1 reset = 1'b1;

        while (!(nacc >= NOPS && p_valid == 2'b00 && (!have_op || cyc > rsp_c))) begin
            if (guard++ > 20000) begin
                tests++;
                fails++;
                $display("FAIL loop_timeout: got %0d accepted, required %0d", nacc, NOPS);
                break;
            end
            @(negedge clk);
            exp_r = 2'b00;
            if (!have_op || cyc > rsp_c)
                exp_r = (p_valid == 2'b11) ? (mprio ? 2'b10 : 2'b01) : p_valid;
            check("ready", {req1_ready, req0_ready}, exp_r);
            check("busy", busy, have_op && cyc > acc_c && cyc <= rsp_c);
            check("alu_start", alu_start, have_op && cyc == acc_c + 1);
            if (have_op && cyc > acc_c)
                check("alu_operands", {alu_mode, alu_op, alu_round, alu_a, alu_b}, exp_opnd);

            if (exp_r != 2'b00) begin
                w = exp_r[1];
                exp_opnd = {p_mode[w], p_op[w], p_round[w],
                            p_mode[w] ? p_a[w] : {16'h0000, p_a[w][15:0]},
                            p_mode[w] ? p_b[w] : {16'h0000, p_b[w][15:0]}};
                mprio = ~w;
                have_op = 1;
                acc_c = cyc;
                pr16 = 16'($urandom); pr32 = $urandom; pf16 = 5'($urandom); pf32 = 5'($urandom);
                d = $urandom_range(1, TO + 3);
                case (nacc)
                    0: begin d = 1; pr16 = 16'h4200; pf16 = 5'b00000; end
                    1: begin d = 5; pr32 = 32'h40400000; pf32 = 5'b00010; end
                    2: d = TO + 3;
                    3: d = TO;
                    default: ;
                endcase
                if (d <= TO) begin
                    done_en = 1;
                    done_c = cyc + 1 + d;
                    rsp_c = done_c + 1;
                    x = '{w, p_mode[w] ? pr32 : {16'h0000, pr16}, p_mode[w] ? pf32 : pf16, 1'b0, rsp_c};
                end else begin
                    done_en = 0;
                    rsp_c = cyc + 2 + TO;
                    x = '{w, 32'h0, 5'h0, 1'b1, rsp_c};
                end
                exp_q.push_back(x);
                acc_mask[w] = 1'b1;
                nacc++;
            end

            @(posedge clk);
            #1;
            if (done_en && cyc == done_c) begin
                alu_done = 1'b1;
                r16 = pr16; r32 = pr32; f16 = pf16; f32 = pf32;
            end else begin
                alu_done = !(have_op && cyc >= acc_c + 2 && cyc < rsp_c) && ($urandom_range(0, 3) == 0);
                r16 = 16'($urandom); r32 = $urandom; f16 = 5'($urandom); f32 = 5'($urandom);
            end
            for (int i = 0; i < 2; i++) begin
                if (acc_mask[i]) begin
                    new_req(i);
                    p_valid[i] = (nacc < NOPS) && ($urandom_range(0, 3) != 0);
                end else if (!p_valid[i] && nacc < NOPS && $urandom_range(0, 1) == 1) begin
                    new_req(i);
                    p_valid[i] = 1'b1;
                end
            end
            acc_mask = '0;
        end

        // Reset during WAIT: everything clears, a late done is ignored, prio returns to req0.
        alu_done = 1'b0;
        p_valid = 2'b01;
        @(negedge clk);
        check("rst_accept", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1 p_valid = 2'b00;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1 check("reset_outputs", {req0_ready, req1_ready, alu_start, alu_mode, alu_a, alu_b, alu_op,
                                   alu_round, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_timeout, busy}, '0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 alu_done = 1'b1;
        @(posedge clk);
        #1 alu_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("idle_after_reset", {busy, alu_start}, 2'b00);
        end
        p_valid = 2'b11;
        #1 check("prio_after_reset", {req1_ready, req0_ready}, 2'b01);
        p_valid = 2'b00;
        @(negedge clk);
        check("queue_drained", 96'(exp_q.size()), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_op_arbiter.md
# fp_op_arbiter

Shares the single floating-point ALU (16-bit and 32-bit paths, 2-bit op code, round-mode bit) between two requesters, e.g. the front-panel sequencer and a self-test/stream source. It arbitrates round-robin, issues one operation at a time with a start/done handshake, selects the 16-bit or 32-bit result and flags, and returns them tagged with the requester ID. A watchdog aborts operations whose `alu_done` never arrives.

## Interface
- `TIMEOUT`, default 64: number of WAIT cycles without `alu_done` before the operation is aborted. Legal range 2..65535.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has an operation pending.
- `req0_mode` in 1: 0 = 16-bit, 1 = 32-bit.
- `req0_a`, `req0_b` in 32 each: operands; only bits [15:0] are used in 16-bit mode.
- `req0_op` in 2: op code.
- `req0_round` in 1: round mode.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req1_valid`, `req1_mode`, `req1_a`, `req1_b`, `req1_op`, `req1_round`, `req1_ready`: same as requester 0, for requester 1.
- `alu_start` out 1: one-cycle issue pulse to the ALU.
- `alu_mode` out 1, `alu_a` out 32, `alu_b` out 32, `alu_op` out 2, `alu_round` out 1: registered operands to the ALU.
- `alu_done` in 1: ALU result valid.
- `r16` in 16, `r32` in 32: ALU results.
- `f16` in 5, `f32` in 5: ALU flags.
- `rsp_valid` out 1: one-cycle response strobe.
- `rsp_id` out 1: requester that owns the response.
- `rsp_result` out 32: the result.
- `rsp_flags` out 5: the flags.
- `rsp_timeout` out 1: the operation was aborted by the watchdog.
- `busy` out 1: high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP. `prio` is a 1-bit register holding the index of the requester favoured on a conflict.
- IDLE:
  - `req0_ready` = `req0_valid` & (!`req1_valid` | `prio`==0).
  - `req1_ready` = `req1_valid` & (!`req0_valid` | `prio`==1).
  - Both ready signals are 0 in every other state.
  - Handshake: a request is accepted when valid & ready. On acceptance, latch mode/a/b/op/round into the `alu_*` registers and the requester index into `owner`; set `prio` to !`owner`; go to ISSUE.
- 16-bit mode: latch `alu_a` = {16'h0000, a[15:0]} and `alu_b` = {16'h0000, b[15:0]}.
- ISSUE:
  - `alu_start` = 1 for exactly this one cycle.
  - Clear the watchdog counter; go to WAIT.
  - `alu_done` is ignored in ISSUE.
- WAIT:
  - If `alu_done` = 1, capture the result and go to RESP.
    - `alu_mode` = 0: `rsp_result` = {16'h0000, `r16`}, `rsp_flags` = `f16`.
    - `alu_mode` = 1: `rsp_result` = `r32`, `rsp_flags` = `f32`.
    - `rsp_timeout` = 0.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no done, go to RESP with `rsp_result` = 0, `rsp_flags` = 0, `rsp_timeout` = 1.
  - If `alu_done` arrives in the same cycle as counter expiry, done wins (normal result, `rsp_timeout` = 0).
- RESP:
  - `rsp_valid` = 1 for one cycle, `rsp_id` = `owner`; go to IDLE.
  - No backpressure: requesters must accept the response.
- The `alu_*` operands stay stable from ISSUE until the next acceptance.
- `rsp_result`, `rsp_flags`, `rsp_id` and `rsp_timeout` hold their values until the next RESP.
- Invalid state encodings go to IDLE.

## Timing
- Reset (`reset` low), applied asynchronously and at any time, including mid-operation:
  - state = IDLE, `prio` = 0, counter = 0.
  - All outputs = 0, including `alu_start`, `rsp_valid` and `busy`.
  - An in-flight ALU operation is abandoned; a late `alu_done` arriving in IDLE is ignored.
- Acceptance happens in cycle T. `alu_start` is high in T+1. WAIT starts at T+2.
- `alu_done` sampled high in cycle D (D ≥ T+2) gives `rsp_valid` in D+1 and IDLE in D+2. The earliest next acceptance is in D+2.
- Minimum turnaround is 4 cycles per operation, when `alu_done` is high in the first WAIT cycle.
- Timeout: with no done, the watchdog expires in the cycle T+1+TIMEOUT, giving `rsp_valid` with `rsp_timeout` in T+2+TIMEOUT.
- `busy` is high from T+1 through the RESP cycle inclusive.
- Requests that are valid while the block is busy wait; they must hold valid and payload stable until ready.

## Test plan
- Reset, then req0: mode=0, a=16'h3C00, b=16'h4000, op=0. ALU returns r16=16'h4200, f16=0 one cycle after start. Required: `alu_a` = 32'h00003C00; `rsp_valid` with `rsp_id`=0, `rsp_result`=32'h00004200; total 4 cycles from acceptance to IDLE.
- req1 in 32-bit mode: a=32'h3F800000, b=32'h40000000, ALU done after 5 cycles with r32=32'h40400000, f32=5'b00010. Required: `rsp_id`=1, `rsp_result`=32'h40400000, `rsp_flags`=5'b00010, `rsp_valid` 1 cycle after done.
- req0 and req1 both held valid for 4 operations. Required: grants alternate 0,1,0,1; `ready` is never high in both requesters at once.
- TIMEOUT=8, `alu_done` tied low. Required: `rsp_valid` at acceptance+10, `rsp_timeout`=1, `rsp_result`=0; the block then accepts the next request.
- `alu_done` asserted exactly in the expiry cycle. Required: normal result, `rsp_timeout`=0.
- Reset asserted during WAIT, then `alu_done` pulses after release. Required: all outputs 0 immediately; no `rsp_valid`; `prio`=0, so req0 wins a following conflict.
